// File: rtl/spi_tx_queue.sv
// Byte FIFO feeding an SPI master transmitter: launches one byte per one-cycle
// enable pulse, paced on the transmitter busy flag, with a sticky ack-timeout flag.
`timescale 1ns/1ps
module spi_tx_queue #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 16,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_valid_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  output logic                     wr_ready_o,
  input  logic                     spi_busy_i,
  output logic                     spi_tx_en_o,
  output logic [DATA_W-1:0]        spi_tx_data_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     ack_err_o,
  input  logic                     err_clr_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_ACK,
    WAIT_DONE,
    GAP
  } state_t;

  logic [DATA_W-1:0] mem_q [DEPTH];

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              full_q, full_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tx_en_q, tx_en_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              err_q, err_d;

  logic push;
  logic pop;
  logic timeout;

  // Full is registered, so a write offered on the edge that pops a full queue is refused.
  assign push = wr_valid_i && !full_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tx_en_d   = 1'b0;
    tx_data_d = tx_data_q;
    pop       = 1'b0;
    timeout   = 1'b0;
    case (state_q)
      IDLE: begin
        if ((level_q != LVL_W'(0)) && !spi_busy_i) begin
          pop       = 1'b1;
          tx_en_d   = 1'b1;
          tx_data_d = mem_q[rd_ptr_q];
          state_d   = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (spi_busy_i) begin
          state_d = WAIT_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          // Counter reaches ACK_TIMEOUT on this edge: give up and drop the byte.
          if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
            timeout = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (!spi_busy_i) begin
          state_d = GAP;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    full_d = (level_d == LVL_W'(DEPTH));
  end

  // A timeout on the same edge as a clear leaves the flag set.
  always_comb begin
    err_d = err_q;
    if (err_clr_i) begin
      err_d = 1'b0;
    end
    if (timeout) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      full_q    <= 1'b0;
      cnt_q     <= '0;
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      full_q    <= full_d;
      cnt_q     <= cnt_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
      err_q     <= err_d;
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers and level.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign wr_ready_o    = !full_q;
  assign spi_tx_en_o   = tx_en_q;
  assign spi_tx_data_o = tx_data_q;
  assign level_o       = level_q;
  assign ack_err_o     = err_q;

endmodule

// File: tb/tb_spi_tx_queue.sv
// Directed bench for spi_tx_queue: a scoreboard queue is filled on accepted writes
// and a negedge monitor pops and compares on every launch pulse.
`timescale 1ns/1ps
module tb_spi_tx_queue;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int TMO   = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready_o;
  logic          spi_busy = 1'b0;
  logic          spi_tx_en_o;
  logic [DW-1:0] spi_tx_data_o;
  logic [4:0]    level_o;
  logic          ack_err_o;
  logic          err_clr = 1'b0;

  spi_tx_queue #(.DATA_W(DW), .DEPTH(DEPTH), .ACK_TIMEOUT(TMO)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .wr_valid_i(wr_valid),
    .wr_data_i(wr_data),
    .wr_ready_o(wr_ready_o),
    .spi_busy_i(spi_busy),
    .spi_tx_en_o(spi_tx_en_o),
    .spi_tx_data_o(spi_tx_data_o),
    .level_o(level_o),
    .ack_err_o(ack_err_o),
    .err_clr_i(err_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int last_pulse_cyc = 0;
  int prev_cyc = 0;
  int gap_exp = 20;
  bit gap_chk = 1'b0;
  bit prev_valid = 1'b0;
  bit prev_en = 1'b0;
  int mode = 0;       // 0: busy low, 1: transmitter model, 2: busy held high
  int busy_len = 16;
  int bcnt = 0;
  logic [DW-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transmitter model: busy rises before the edge after the pulse, held busy_len cycles.
  always begin
    @(negedge clk);
    #1;
    if (mode == 1) begin
      if (spi_tx_en_o) bcnt = busy_len + 1;
      else if (bcnt > 0) bcnt = bcnt - 1;
      spi_busy = (bcnt > 0);
    end else begin
      bcnt = 0;
      spi_busy = (mode == 2);
    end
  end

  // Monitor: every launch pulse is compared against the scoreboard head.
  always @(negedge clk) begin
    if (spi_tx_en_o) begin
      if (prev_en) chk("pulse_width", 2, 1);
      pulse_cnt = pulse_cnt + 1;
      last_pulse_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", int'(spi_tx_data_o), -1);
      end else begin
        chk("tx_data_order", int'(spi_tx_data_o), int'(exp_q.pop_front()));
      end
      if (gap_chk && prev_valid) chk("launch_spacing", cyc - prev_cyc, gap_exp);
      prev_valid = 1'b1;
      prev_cyc = cyc;
    end
    prev_en = spi_tx_en_o;
  end

  task automatic wr(input logic [DW-1:0] d, output int acc);
    bit done;
    done = 1'b0;
    acc = -1;
    @(negedge clk);
    wr_valid = 1'b1;
    wr_data = d;
    for (int k = 0; k < 200 && !done; k++) begin
      if (wr_ready_o) begin
        exp_q.push_back(d);
        acc = cyc + 1;
        done = 1'b1;
        @(posedge clk);
      end else begin
        @(negedge clk);
      end
    end
    if (!done) chk("write_accept", 0, 1);
  endtask

  task automatic wait_pulses(input int target, input int budget);
    for (int k = 0; k < budget && pulse_cnt < target; k++) @(negedge clk);
    chk("pulse_count", pulse_cnt, target);
  endtask

  task automatic wait_err(input int p);
    int k;
    k = 0;
    while (!ack_err_o && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("timeout_edge", cyc - p, TMO + 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int p;
    int base;

    repeat (3) @(negedge clk);
    chk("rst_wr_ready", int'(wr_ready_o), 1);
    chk("rst_level", int'(level_o), 0);
    chk("rst_tx_en", int'(spi_tx_en_o), 0);
    chk("rst_tx_data", int'(spi_tx_data_o), 0);
    chk("rst_ack_err", int'(ack_err_o), 0);
    rst = 1'b0;

    // single byte
    mode = 1;
    busy_len = 16;
    base = pulse_cnt;
    wr(8'hA5, acc);
    @(negedge clk);
    wr_valid = 1'b0;
    chk("single_pre_en", int'(spi_tx_en_o), 0);
    chk("single_level_up", int'(level_o), 1);
    @(negedge clk);
    chk("single_en", int'(spi_tx_en_o), 1);
    chk("single_data", int'(spi_tx_data_o), 8'hA5);
    chk("single_level_down", int'(level_o), 0);
    @(negedge clk);
    chk("single_en_fall", int'(spi_tx_en_o), 0);
    repeat (40) @(negedge clk);
    chk("single_count", pulse_cnt, base + 1);
    chk("single_latency", last_pulse_cyc, acc + 1);
    chk("data_hold", int'(spi_tx_data_o), 8'hA5);

    // burst 0x01..0x10 while transmitter holds busy
    mode = 2;
    base = pulse_cnt;
    for (int i = 1; i <= 16; i++) wr(8'(i), acc);
    @(negedge clk);
    wr_valid = 1'b0;
    chk("burst_full_level", int'(level_o), 16);
    chk("burst_full_ready", int'(wr_ready_o), 0);
    wr_valid = 1'b1;
    wr_data = 8'h77;
    @(negedge clk);
    wr_valid = 1'b0;
    chk("refused_level", int'(level_o), 16);
    gap_chk = 1'b1;
    prev_valid = 1'b0;
    mode = 1;
    wait_pulses(base + 16, 400);
    chk("burst_drained", int'(level_o), 0);
    repeat (25) @(negedge clk);

    // second burst wraps pointers, then full-plus-pop collision
    mode = 2;
    gap_chk = 1'b0;
    base = pulse_cnt;
    for (int i = 0; i < 16; i++) wr(8'h11 + 8'(i), acc);
    @(negedge clk);
    wr_valid = 1'b0;
    chk("burst2_level", int'(level_o), 16);
    @(negedge clk);
    chk("collide_full_ready", int'(wr_ready_o), 0);
    wr_valid = 1'b1;
    wr_data = 8'h21;
    mode = 1;
    gap_chk = 1'b1;
    prev_valid = 1'b0;
    @(negedge clk);
    chk("collide_level", int'(level_o), 15);
    chk("collide_en", int'(spi_tx_en_o), 1);
    chk("collide_ready", int'(wr_ready_o), 1);
    exp_q.push_back(8'h21);
    @(negedge clk);
    wr_valid = 1'b0;
    chk("collide_accept", int'(level_o), 16);
    wait_pulses(base + 17, 450);
    repeat (25) @(negedge clk);

    // ack timeout
    mode = 0;
    gap_chk = 1'b0;
    base = pulse_cnt;
    wr(8'h5A, acc);
    @(negedge clk);
    wr_valid = 1'b0;
    wait_pulses(base + 1, 10);
    p = last_pulse_cyc;
    wait_err(p);
    chk("timeout_flag", int'(ack_err_o), 1);
    mode = 1;
    wr(8'h3C, acc);
    @(negedge clk);
    wr_valid = 1'b0;
    wait_pulses(base + 2, 20);
    chk("post_timeout_latency", last_pulse_cyc, acc + 1);
    repeat (25) @(negedge clk);
    chk("err_sticky", int'(ack_err_o), 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clear", int'(ack_err_o), 0);

    // timeout while clear is held: set wins
    mode = 0;
    err_clr = 1'b1;
    base = pulse_cnt;
    wr(8'h99, acc);
    @(negedge clk);
    wr_valid = 1'b0;
    wait_pulses(base + 1, 10);
    p = last_pulse_cyc;
    wait_err(p);
    chk("set_wins", int'(ack_err_o), 1);
    err_clr = 1'b0;
    @(negedge clk);
    chk("set_wins_hold", int'(ack_err_o), 1);
    repeat (5) @(negedge clk);

    // asynchronous reset during WAIT_DONE with 5 bytes queued
    mode = 1;
    base = pulse_cnt;
    for (int i = 0; i < 6; i++) wr(8'hB0 + 8'(i), acc);
    @(negedge clk);
    wr_valid = 1'b0;
    chk("pre_reset_level", int'(level_o), 5);
    chk("pre_reset_pulses", pulse_cnt, base + 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_level", int'(level_o), 0);
    chk("async_rst_tx_en", int'(spi_tx_en_o), 0);
    chk("async_rst_ready", int'(wr_ready_o), 1);
    chk("async_rst_err", int'(ack_err_o), 0);
    chk("async_rst_data", int'(spi_tx_data_o), 0);
    exp_q.delete();
    mode = 0;
    @(negedge clk);
    rst = 1'b0;
    base = pulse_cnt;
    repeat (40) @(negedge clk);
    chk("no_pulse_after_reset", pulse_cnt, base);
    chk("post_reset_level", int'(level_o), 0);
    mode = 1;
    wr(8'hC3, acc);
    @(negedge clk);
    wr_valid = 1'b0;
    wait_pulses(base + 1, 20);
    chk("post_reset_latency", last_pulse_cyc, acc + 1);
    repeat (25) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
